updown_cmd_arbiter: RTL and testbench

Command sequencer and two-port round-robin arbiter for the shared up/down counter. Each requester submits a (direction, step-count) command over a valid/ready handshake. The granted command drives the counter's enable and mode lines for exactly the requested number of clocks, then reports completion to the owning requester. The block sits between the requesting control logic and one up/down counter instance whose `mode` input is 1 = up and 0 = down, with a count-enable added.

---
 rtl/updown_cmd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_updown_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_cmd_arbiter.sv
// updown_cmd_arbiter
// Command sequencer and two-port round-robin arbiter for a shared up/down
// counter. Each requester hands over a (direction, step-count) command via
// valid/ready. The granted command drives cnt_en/cnt_mode for exactly the
// requested number of clocks, then a one-cycle done pulse reports back to
// the owning requester.
//
// Ports
//   clk                  sole clock, rising edge
//   rst                  asynchronous active-high reset
//   req0_valid/dir/len   requester 0 command (dir: 1 = up, 0 = down)
//   req0_ready           requester 0 command accepted this cycle
//   req1_*               same, for requester 1
//   abort                synchronous abort of the running command
//   cnt_en               counter advances one step on each clk edge where high
//   cnt_mode             counter direction (1 = up)
//   busy                 command in progress (state != IDLE)
//   owner                requester index of the current or last command
//   done                 one-cycle completion pulse
//   done_id              requester index for done
//   done_abort           qualifies done: the command was aborted
module updown_cmd_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  input  logic             abort,
  output logic             cnt_en,
  output logic             cnt_mode,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic             done_id,
  output logic             done_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] rem_r;
  logic             prio_r;
  logic             owner_r;
  logic             mode_r;
  logic             done_r;
  logic             done_id_r;
  logic             done_abort_r;

  logic             gnt_valid_s;
  logic             gnt_id_s;
  logic             gnt_dir_s;
  logic [LEN_W-1:0] gnt_len_s;

  // Round-robin pick in IDLE: prio only breaks ties when both are valid.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = prio_r;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = prio_r;
      end else if (req0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = prio_r;
      end
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = prio_r;
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    if (gnt_id_s) begin
      gnt_dir_s = req1_dir;
      gnt_len_s = req1_len;
    end else begin
      gnt_dir_s = req0_dir;
      gnt_len_s = req0_len;
    end
  end

  assign req0_ready = gnt_valid_s & ~gnt_id_s;
  assign req1_ready = gnt_valid_s &  gnt_id_s;

  // Abort must suppress the step in the same cycle, so cnt_en is gated
  // combinationally; the state register's async reset drops it instantly.
  assign cnt_en     = (state_r == RUN) & ~abort;
  assign cnt_mode   = mode_r;
  assign busy       = (state_r != IDLE);
  assign owner      = owner_r;
  assign done       = done_r;
  assign done_id    = done_id_r;
  assign done_abort = done_abort_r;

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      rem_r        <= '0;
      prio_r       <= 1'b0;
      owner_r      <= 1'b0;
      mode_r       <= 1'b1;
      done_r       <= 1'b0;
      done_id_r    <= 1'b0;
      done_abort_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r       <= 1'b0;
          done_abort_r <= 1'b0;
          if (gnt_valid_s) begin
            owner_r <= gnt_id_s;
            rem_r   <= gnt_len_s;
            if (gnt_len_s != '0) begin
              mode_r  <= gnt_dir_s;
              state_r <= RUN;
            end else begin
              // No-op command: report completion straight away.
              state_r   <= DONE;
              done_r    <= 1'b1;
              done_id_r <= gnt_id_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state_r      <= DONE;
            done_r       <= 1'b1;
            done_id_r    <= owner_r;
            done_abort_r <= 1'b1;
          end else begin
            rem_r <= rem_r - LEN_W'(1);
            // Exit on rem = 1 so rem never wraps below zero.
            if (rem_r == LEN_W'(1)) begin
              state_r   <= DONE;
              done_r    <= 1'b1;
              done_id_r <= owner_r;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          done_r       <= 1'b0;
          done_abort_r <= 1'b0;
          prio_r       <= ~owner_r;
          state_r      <= IDLE;
        end
        default: begin
          done_r       <= 1'b0;
          done_abort_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_cmd_arbiter.sv
// Scoreboard bench for updown_cmd_arbiter. A 3-bit up/down counter model is
// driven by cnt_en/cnt_mode; drivers push the expected completion of every
// accepted command, and a monitor pops and compares on each done pulse.
module tb_updown_cmd_arbiter;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_dir, req0_ready;
  logic [LEN_W-1:0] req0_len;
  logic             req1_valid, req1_dir, req1_ready;
  logic [LEN_W-1:0] req1_len;
  logic             abort;
  logic             cnt_en, cnt_mode, busy, owner, done, done_id, done_abort;

  updown_cmd_arbiter #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_len(req1_len), .req1_ready(req1_ready),
    .abort(abort), .cnt_en(cnt_en), .cnt_mode(cnt_mode), .busy(busy), .owner(owner),
    .done(done), .done_id(done_id), .done_abort(done_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic       ab;
    int         steps;
    logic [2:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [2:0] ctr = 3'd0;
  int         steps = 0;
  logic [2:0] exp_ctr = 3'd0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // cycle index; a cycle runs from one rising edge to the next
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: counter model, handshake sanity, scoreboard compare on done
  always @(negedge clk) begin
    if (rst) begin
      ctr   = 3'd0;
      steps = 0;
    end else begin
      chk("ready_exclusive", int'(req0_ready & req1_ready), 0);
      chk("ready_low_when_busy", int'(busy & (req0_ready | req1_ready)), 0);
      if (cnt_en) begin
        ctr = cnt_mode ? ctr + 3'd1 : ctr - 3'd1;
        steps++;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_id", int'(done_id), int'(mon_e.id));
          chk("done_abort", int'(done_abort), int'(mon_e.ab));
          chk("step_count", steps, mon_e.steps);
          chk("counter_value", int'(ctr), int'(mon_e.cnt));
          chk("done_cycle", cyc, mon_e.cyc);
        end
        steps = 0;
      end
    end
  end

  task automatic push(input logic id, input logic dir, input int nsteps, input logic ab, input int dcyc);
    exp_t e;
    exp_ctr = dir ? exp_ctr + 3'(nsteps) : exp_ctr - 3'(nsteps);
    e.id = id; e.ab = ab; e.steps = nsteps; e.cnt = exp_ctr; e.cyc = dcyc;
    sbq.push_back(e);
  endtask

  task automatic wait_ready(input logic id, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) && !ok) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", 1, 0);
  endtask

  task automatic drive(input logic id, input logic v, input logic dir, input logic [LEN_W-1:0] len);
    if (id) begin
      req1_valid = v; req1_dir = dir; req1_len = len;
    end else begin
      req0_valid = v; req0_dir = dir; req0_len = len;
    end
  endtask

  // single command; abort_at > 0 asserts abort in that RUN cycle (1-based)
  task automatic issue(input logic id, input logic dir, input logic [LEN_W-1:0] len, input int abort_at);
    logic ok;
    int   t;
    @(posedge clk); #1;
    drive(id, 1'b1, dir, len);
    wait_ready(id, ok);
    t = cyc;
    if (ok) begin
      if (abort_at > 0) push(id, dir, abort_at - 1, 1'b1, t + abort_at + 1);
      else              push(id, dir, int'(len), 1'b0, t + int'(len) + 1);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, dir, len);
    if (ok && abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      chk("cnt_en_low_on_abort", int'(cnt_en), 0);
      @(posedge clk); #1 abort = 1'b0;
    end
  endtask

  // both requesters held valid; grants must alternate starting at 'first'
  task automatic pair(input logic d0, input logic [LEN_W-1:0] l0, input logic d1,
                      input logic [LEN_W-1:0] l1, input logic first, input int n);
    logic ok;
    logic gid;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, d0, l0);
    drive(1'b1, 1'b1, d1, l1);
    for (int k = 0; k < n; k++) begin
      ok = 1'b0;
      for (int w = 0; w < 60; w++) begin
        @(negedge clk);
        if ((req0_ready || req1_ready) && !ok) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk("pair_timeout", 1, 0);
        break;
      end
      gid = req1_ready;
      chk("grant_order", int'(gid), int'(first ^ k[0]));
      push(gid, gid ? d1 : d0, gid ? int'(l1) : int'(l0), 1'b0, cyc + (gid ? int'(l1) : int'(l0)) + 1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, d0, l0);
    drive(1'b1, 1'b0, d1, l1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    @(posedge clk);
  endtask

  initial begin
    logic ok;
    rst = 1'b0; abort = 1'b0;
    req0_valid = 1'b0; req0_dir = 1'b0; req0_len = '0;
    req1_valid = 1'b0; req1_dir = 1'b0; req1_len = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_done_abort", int'(done_abort), 0);
    chk("rst_cnt_mode", int'(cnt_mode), 1);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;

    // up 5 from 0 -> 5; then down 7 wraps to 6
    issue(1'b0, 1'b1, 4'd5, 0);
    drain();
    issue(1'b1, 1'b0, 4'd7, 0);
    drain();

    // zero-length command, then prio has flipped to requester 1
    issue(1'b0, 1'b1, 4'd0, 0);
    drain();
    pair(1'b1, 4'd1, 1'b0, 4'd1, 1'b1, 1);
    drain();

    // abort held in IDLE does nothing
    @(posedge clk); #1 abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    @(posedge clk); #1 abort = 1'b0;
    // abort on 4th RUN cycle: 3 steps; abort on final cycle of len 2: 1 step
    issue(1'b1, 1'b1, 4'd10, 4);
    drain();
    issue(1'b0, 1'b1, 4'd2, 2);
    drain();

    // reset between edges mid-RUN: command lost, outputs drop at once
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'd8);
    wait_ready(1'b0, ok);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 4'd8);
    @(posedge clk); #2;
    chk("run_before_rst", int'(cnt_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_cnt_en", int'(cnt_en), 0);
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_done", int'(done), 0);
    chk("midrun_rst_cnt_mode", int'(cnt_mode), 1);
    exp_ctr = 3'd0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    // both valid from reset, len 2: grants 0,1,0,1, done every 4 cycles
    pair(1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 4);
    drain();

    repeat (5) @(posedge clk);
    chk("queue_empty_at_end", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
